// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, one bit per cycle, with start/busy/done handshake.
module muldiv_unit #(
   parameter int REG_DATA_WIDTH_POW = 6
) (
   input  logic                                 clk_in,
   input  logic                                 reset,
   input  logic                                 start_in,
   input  logic [2:0]                           op_in,
   input  logic [(1 << REG_DATA_WIDTH_POW)-1:0] operand1_in,
   input  logic [(1 << REG_DATA_WIDTH_POW)-1:0] operand2_in,
   output logic                                 busy_out,
   output logic                                 done_out,
   output logic [(1 << REG_DATA_WIDTH_POW)-1:0] result_out
);

   localparam int XLEN = 1 << REG_DATA_WIDTH_POW;
   localparam int CW   = REG_DATA_WIDTH_POW + 1;

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_t;

   state_t            state, state_next;
   op_t               op;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   addend;
   logic              neg_res, neg_rem, fast;
   logic [CW-1:0]     count;

   logic              sign1, sign2, is_div, div_zero, overflow, fast_path;
   logic [XLEN-1:0]   mag1, mag2, fast_res;
   logic [XLEN:0]     mul_sum, rem_sh, trial;
   logic [2*XLEN-1:0] mul_next, div_next, prod;
   logic [XLEN-1:0]   quo, rem, final_res;

   always_comb begin
      sign1    = ((op_in == 3'b001) || (op_in == 3'b010) || (op_in == 3'b100) || (op_in == 3'b110))
                 && operand1_in[XLEN-1];
      sign2    = ((op_in == 3'b001) || (op_in == 3'b100) || (op_in == 3'b110)) && operand2_in[XLEN-1];
      mag1     = sign1 ? -operand1_in : operand1_in;
      mag2     = sign2 ? -operand2_in : operand2_in;
      is_div   = op_in[2];
      div_zero = is_div && (operand2_in == '0);
      overflow = is_div && !op_in[0] && (operand1_in == {1'b1, {(XLEN-1){1'b0}}})
                 && (operand2_in == '1);
      fast_path = div_zero || overflow;
      if (div_zero) fast_res = op_in[1] ? operand1_in : '1;
      else          fast_res = op_in[1] ? '0 : operand1_in;
   end

   // Multiply: low half of acc holds the shifting multiplier, high half the partial product.
   // Divide: {remainder, quotient} shift left; quotient bits enter at bit 0.
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, addend} : '0);
      mul_next = {mul_sum, acc[XLEN-1:1]};
      rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      trial    = rem_sh - {1'b0, addend};
      div_next = trial[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                             : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   end

   always_comb begin
      prod = neg_res ? -acc : acc;
      quo  = acc[XLEN-1:0];
      rem  = acc[2*XLEN-1:XLEN];
      final_res = '0;
      if (fast) final_res = acc[XLEN-1:0];
      else begin
         unique case (op)
            OP_MUL:                       final_res = acc[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
            OP_DIV:                       final_res = neg_res ? -quo : quo;
            OP_DIVU:                      final_res = quo;
            OP_REM:                       final_res = neg_rem ? -rem : rem;
            OP_REMU:                      final_res = rem;
            default:                      final_res = '0;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start_in) state_next = fast_path ? FINISH : CALC;
         CALC:    if (count == CW'(1)) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy_out = (state != IDLE);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         op         <= OP_MUL;
         acc        <= '0;
         addend     <= '0;
         neg_res    <= 1'b0;
         neg_rem    <= 1'b0;
         fast       <= 1'b0;
         count      <= '0;
         done_out   <= 1'b0;
         result_out <= '0;
      end else begin
         done_out <= 1'b0;
         unique case (state)
            IDLE: if (start_in) begin
               op      <= op_t'(op_in);
               neg_res <= sign1 ^ sign2;
               neg_rem <= sign1;
               fast    <= fast_path;
               count   <= CW'(XLEN);
               if (fast_path) begin
                  acc    <= {{XLEN{1'b0}}, fast_res};
                  addend <= '0;
               end else if (is_div) begin
                  acc    <= {{XLEN{1'b0}}, mag1};
                  addend <= mag2;
               end else begin
                  acc    <= {{XLEN{1'b0}}, mag2};
                  addend <= mag1;
               end
            end
            CALC: begin
               acc   <= op[2] ? div_next : mul_next;
               count <= count - CW'(1);
            end
            FINISH: begin
               done_out   <= 1'b1;
               result_out <= final_res;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at XLEN=64 and XLEN=32 against an
// arithmetic reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        s64, s32;
   logic [2:0]  op64, op32;
   logic [63:0] a64, b64, res64;
   logic [31:0] a32, b32, res32;
   logic        busy64, done64, busy32, done32;
   logic        pd64, pd32;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.REG_DATA_WIDTH_POW(6)) dut64 (
      .clk_in(clk), .reset(rst), .start_in(s64), .op_in(op64),
      .operand1_in(a64), .operand2_in(b64),
      .busy_out(busy64), .done_out(done64), .result_out(res64)
   );

   muldiv_unit #(.REG_DATA_WIDTH_POW(5)) dut32 (
      .clk_in(clk), .reset(rst), .start_in(s32), .op_in(op32),
      .operand1_in(a32), .operand2_in(b32),
      .busy_out(busy32), .done_out(done32), .result_out(res32)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mask_of(input int w);
      return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   // Reference: exact integer arithmetic on wide signed values.
   function automatic logic [63:0] golden(input int w, input logic [2:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
      logic [63:0]        m, am, bm, r;
      logic signed [129:0] ua, ub, sa, sb, p, two_w;
      m     = mask_of(w);
      am    = a & m;
      bm    = b & m;
      two_w = 130'sd1 <<< w;
      ua    = $signed({66'b0, am});
      ub    = $signed({66'b0, bm});
      sa    = am[w-1] ? ua - two_w : ua;
      sb    = bm[w-1] ? ub - two_w : ub;
      r     = '0;
      case (op)
         3'd0: begin p = ua * ub; r = p[63:0]; end
         3'd1: begin p = sa * sb; p = p >>> w; r = p[63:0]; end
         3'd2: begin p = sa * ub; p = p >>> w; r = p[63:0]; end
         3'd3: begin p = ua * ub; p = p >>> w; r = p[63:0]; end
         3'd4: if (bm == 0) r = '1; else begin p = sa / sb; r = p[63:0]; end
         3'd5: if (bm == 0) r = '1; else begin p = ua / ub; r = p[63:0]; end
         3'd6: if (bm == 0) r = am; else begin p = sa % sb; r = p[63:0]; end
         default: if (bm == 0) r = am; else begin p = ua % ub; r = p[63:0]; end
      endcase
      return r & m;
   endfunction

   function automatic int exp_lat(input int w, input logic [2:0] op,
                                  input logic [63:0] a, input logic [63:0] b);
      logic [63:0] m, msb;
      m   = mask_of(w);
      msb = 64'd1 << (w - 1);
      if (op[2] && ((b & m) == 0)) return 1;
      if ((op == 3'd4 || op == 3'd6) && ((a & m) == msb) && ((b & m) == m)) return 1;
      return w + 1;
   endfunction

   function automatic logic [63:0] pick(input int w);
      logic [63:0] r;
      case ($urandom_range(0, 7))
         0: r = 64'd0;
         1: r = 64'd1;
         2: r = '1;
         3: r = 64'd1 << (w - 1);
         4: r = 64'($urandom_range(0, 15));
         default: r = {$urandom, $urandom};
      endcase
      return r & mask_of(w);
   endfunction

   task automatic drive(input int w, input logic st, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b);
      if (w == 64) begin
         s64 = st; op64 = op; a64 = a; b64 = b;
      end else begin
         s32 = st; op32 = op; a32 = a[31:0]; b32 = b[31:0];
      end
   endtask

   // Waits for done after an accept edge already taken; bounded by 200 cycles.
   task automatic wait_done(input int w, output logic [63:0] res, output int lat);
      logic d;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         d = (w == 64) ? done64 : done32;
      end while (!d && lat < 200);
      res = (w == 64) ? res64 : {32'b0, res32};
   endtask

   task automatic run(input int w, input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] b, output logic [63:0] res, output int lat);
      drive(w, 1'b1, op, a, b);
      @(posedge clk); #1;
      drive(w, 1'b0, 3'd0, '0, '0);
      wait_done(w, res, lat);
   endtask

   task automatic run_check(input string tag, input int w, input logic [2:0] op,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] exp_res, input int lat_exp);
      logic [63:0] res;
      int lat;
      run(w, op, a, b, res, lat);
      check({tag, "_res"}, res, exp_res);
      check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
   endtask

   task automatic random_stream(input int w, input int count);
      logic [63:0] a, b, res;
      logic [2:0]  op;
      int lat;
      for (int i = 0; i < count; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = pick(w);
         b  = pick(w);
         run(w, op, a, b, res, lat);
         check((w == 64) ? "rand64_res" : "rand32_res", res, golden(w, op, a, b));
         check((w == 64) ? "rand64_lat" : "rand32_lat", 64'(lat), 64'(exp_lat(w, op, a, b)));
      end
   endtask

   // Protocol: done never coincides with busy and never lasts two cycles.
   always @(negedge clk) begin
      if (!rst) begin
         if (done64) begin
            check("done64_busy", 64'(busy64), 64'd0);
            check("done64_pulse", 64'(pd64), 64'd0);
         end
         if (done32) begin
            check("done32_busy", 64'(busy32), 64'd0);
            check("done32_pulse", 64'(pd32), 64'd0);
         end
      end
      pd64 = done64;
      pd32 = done32;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] res;
      int lat, dones;
      rst = 1'b1;
      drive(64, 1'b0, 3'd0, '0, '0);
      drive(32, 1'b0, 3'd0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy64", 64'(busy64), 64'd0);
      check("rst_done64", 64'(done64), 64'd0);
      check("rst_res64", res64, 64'd0);
      check("rst_busy32", 64'(busy32), 64'd0);
      check("rst_res32", {32'b0, res32}, 64'd0);
      rst = 1'b0;

      run_check("mul_ff_x2", 64, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      @(posedge clk); #1;
      check("mul_done_drop", 64'(done64), 64'd0);
      run_check("mulh_m1", 64, 3'd1, '1, '1, 64'd0, 65);
      run_check("mulhu_ff", 64, 3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      run_check("mulhsu_m1x2", 64, 3'd2, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);

      run_check("div_m7_2", 32, 3'd4, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 33);
      run_check("rem_m7_2", 32, 3'd6, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 33);
      run_check("divu_by0", 32, 3'd5, 64'd7, 64'd0, 64'hFFFF_FFFF, 1);
      run_check("div_ovf", 32, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1);
      run_check("rem_ovf", 32, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1);
      run_check("remu_by0", 32, 3'd7, 64'd9, 64'd0, 64'd9, 1);

      // start held high with changing operands while busy
      drive(64, 1'b1, 3'd5, 64'd100, 64'd7);
      @(posedge clk); #1;
      drive(64, 1'b1, 3'd5, 64'd5, 64'd3);
      wait_done(64, res, lat);
      check("hold_res", res, 64'd14);
      check("hold_lat", 64'(lat), 64'd65);
      run_check("b2b_mul", 64, 3'd0, 64'd3, 64'd5, 64'd15, 65);

      // reset aborts an in-flight multiply
      drive(64, 1'b1, 3'd0, 64'd12345, 64'd678);
      @(posedge clk); #1;
      drive(64, 1'b0, 3'd0, '0, '0);
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", 64'(busy64), 64'd0);
      check("abort_done", 64'(done64), 64'd0);
      check("abort_res", res64, 64'd0);
      dones = 0;
      repeat (70) begin
         @(posedge clk); #1;
         if (done64) dones++;
      end
      check("abort_no_done", 64'(dones), 64'd0);
      run_check("remu_after_rst", 64, 3'd7, 64'd100, 64'd7, 64'd2, 65);

      fork
         random_stream(64, 600);
         random_stream(32, 1000);
      join

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
